// File: rtl/rxc_pkg.sv
// rtl/rxc_pkg.sv - shared state encoding, register indices and default widths for reg_xfer_ctrl
package rxc_pkg;

    localparam int NREG_DEF  = 8;
    localparam int BUS_W_DEF = 16;
    localparam int ID_W_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        DONE
    } rxc_state_t;

    // Bus register indices as wired in the downsampling processor's register file
    localparam logic [2:0] REG_TR  = 3'd0;
    localparam logic [2:0] REG_AR  = 3'd1;
    localparam logic [2:0] REG_PC  = 3'd2;
    localparam logic [2:0] REG_AC  = 3'd3;
    localparam logic [2:0] REG_DR  = 3'd4;
    localparam logic [2:0] REG_IR  = 3'd5;
    localparam logic [2:0] REG_R   = 3'd6;
    localparam logic [2:0] REG_TMP = 3'd7;

endpackage

// File: rtl/reg_xfer_ctrl_onehot_dec.sv
// rtl/reg_xfer_ctrl_onehot_dec.sv - enabled index-to-one-hot decoder; out-of-range indices give all zeros
module onehot_dec #(
    parameter int ID_W = 3,
    parameter int NREG = 8
) (
    input  logic            en,
    input  logic [ID_W-1:0] idx,
    output logic [NREG-1:0] dec
);

    always_comb begin
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            dec[i] = en && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// rtl/reg_xfer_ctrl.sv - register-transfer initiator for the shared datapath bus; RXC_ERR_EN adds sticky err
module reg_xfer_ctrl
    import rxc_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int BUS_W = BUS_W_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_src,
    input  logic [ID_W-1:0]  req_dst,
    input  logic             req_imm_sel,
    input  logic [BUS_W-1:0] req_imm,
    input  logic [BUS_W-1:0] bus_in,
    output logic [NREG-1:0]  read_en,
    output logic [NREG-1:0]  write_en,
    output logic [BUS_W-1:0] bus_out,
    output logic             done
`ifdef RXC_ERR_EN
    ,
    output logic             err
`endif
);

    rxc_state_t       state, state_nx;
    logic [ID_W-1:0]  src_q, dst_q;
    logic [BUS_W-1:0] data_q;
    logic             accept;
    logic             rd_go, wr_go;

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                src_q <= req_src;
                dst_q <= req_dst;
                if (req_imm_sel) begin
                    data_q <= req_imm;
                end
            end else if (state == CAPT) begin
                // source registered its value at the end of READ
                data_q <= bus_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = req_imm_sel ? WRITE : READ;
            READ:    state_nx = CAPT;
            CAPT:    state_nx = WRITE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rd_go     = (state == READ);
        wr_go     = (state == WRITE);
        done      = (state == DONE);
        bus_out   = wr_go ? data_q : '0;
    end

    onehot_dec #(.ID_W(ID_W), .NREG(NREG)) u_read_dec (
        .en  (rd_go),
        .idx (src_q),
        .dec (read_en)
    );

    onehot_dec #(.ID_W(ID_W), .NREG(NREG)) u_write_dec (
        .en  (wr_go),
        .idx (dst_q),
        .dec (write_en)
    );

`ifdef RXC_ERR_EN
    logic bad_idx;
    logic err_q;

    assign bad_idx = (!req_imm_sel && int'(req_src) >= NREG) || (int'(req_dst) >= NREG);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((accept && bad_idx) ||
                     (((state == IDLE) || (state == WRITE)) && (bus_in != '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb/tb_reg_xfer_ctrl.sv - self-checking bench for reg_xfer_ctrl (8- and 6-register instances); RXC_ERR_EN aware
module tb_reg_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_src, req_dst;
    logic        req_imm_sel;
    logic [15:0] req_imm;
    logic [15:0] bus_in;
    logic        req_ready, done;
    logic [7:0]  read_en, write_en;
    logic [15:0] bus_out;

    logic        ready6, done6;
    logic [5:0]  re6, we6;
    logic [15:0] bus_out6;
    logic [15:0] bus_in6;
`ifdef RXC_ERR_EN
    logic        err, err6;
`endif

    always #5 clk = ~clk;

    reg_xfer_ctrl #(.NREG(8), .BUS_W(16), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_imm_sel(req_imm_sel), .req_imm(req_imm),
        .bus_in(bus_in), .read_en(read_en), .write_en(write_en), .bus_out(bus_out), .done(done)
`ifdef RXC_ERR_EN
        , .err(err)
`endif
    );

    reg_xfer_ctrl #(.NREG(6), .BUS_W(16), .ID_W(3)) dut6 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready6),
        .req_src(req_src), .req_dst(req_dst), .req_imm_sel(req_imm_sel), .req_imm(req_imm),
        .bus_in(bus_in6), .read_en(re6), .write_en(we6), .bus_out(bus_out6), .done(done6)
`ifdef RXC_ERR_EN
        , .err(err6)
`endif
    );

    // register file environment: registered out_bus, write on write_en
    logic [15:0] regs [8];
    logic [15:0] outq [8];
    logic        env_init;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (env_init) begin
                regs[i] <= 16'h00A4 + 16'(i);
                outq[i] <= 16'h0;
            end else begin
                if (write_en[i]) regs[i] <= bus_out;
                outq[i] <= read_en[i] ? regs[i] : 16'h0;
            end
        end
    end

    always_comb begin
        bus_in = 16'h0;
        for (int i = 0; i < 8; i++) bus_in = bus_in | outq[i];
    end

    logic [15:0] mdl [8];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [2:0] s, input logic [2:0] d, input logic is, input logic [15:0] im,
                        input logic [7:0] ere, input logic [7:0] ewe, input logic [15:0] ebus);
        logic [5:0]  ere6, ewe6;
        logic [15:0] ebus6;
        int n;
        ere6  = (!is && s < 3'd6) ? (6'd1 << s) : 6'd0;
        ewe6  = (d < 3'd6) ? (6'd1 << d) : 6'd0;
        ebus6 = is ? im : 16'h0;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_src = s; req_dst = d; req_imm_sel = is; req_imm = im;
        @(negedge clk);
        req_valid = 1'b0;
        if (!is) begin
            chk("read_en", 32'(read_en), 32'(ere));
            chk("read_en6", 32'(re6), 32'(ere6));
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("we_in_read", 32'(write_en), 32'd0);
            @(negedge clk);
            chk("capt_enables", 32'({read_en, write_en}), 32'd0);
            @(negedge clk);
        end
        chk("write_en", 32'(write_en), 32'(ewe));
        chk("bus_out", 32'(bus_out), 32'(ebus));
        chk("write_en6", 32'(we6), 32'(ewe6));
        chk("bus_out6", 32'(bus_out6), 32'(ebus6));
        chk("re_in_write", 32'(read_en), 32'd0);
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("done6", 32'(done6), 32'd1);
        chk("bus_after", 32'(bus_out), 32'd0);
        chk("dst_reg", 32'(regs[d]), 32'(ebus));
        @(negedge clk);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("done_clear", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  src;
        logic [2:0]  dst;
        logic        imm_sel;
        logic [15:0] imm;
        logic [7:0]  re;
        logic [7:0]  we;
        logic [15:0] bus;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [2:0]  s, d;
        logic        is;
        logic [15:0] im, ebus;
        int          overlap;

        tbl[0] = '{3'd1, 3'd2, 1'b0, 16'h0000, 8'h02, 8'h04, 16'h00A5};
        tbl[1] = '{3'd0, 3'd0, 1'b1, 16'h1234, 8'h00, 8'h01, 16'h1234};
        tbl[2] = '{3'd2, 3'd3, 1'b0, 16'h0000, 8'h04, 8'h08, 16'h00A5};
        tbl[3] = '{3'd0, 3'd0, 1'b0, 16'h0000, 8'h01, 8'h01, 16'h1234};
        tbl[4] = '{3'd3, 3'd7, 1'b1, 16'hBEEF, 8'h00, 8'h80, 16'hBEEF};
        tbl[5] = '{3'd7, 3'd5, 1'b0, 16'h0000, 8'h80, 8'h20, 16'hBEEF};

        for (int i = 0; i < 8; i++) mdl[i] = 16'h00A4 + 16'(i);
        rst = 1'b1; env_init = 1'b1; bus_in6 = 16'h0;
        req_valid = 1'b0; req_src = 3'd0; req_dst = 3'd0; req_imm_sel = 1'b0; req_imm = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0; env_init = 1'b0;

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_read_en", 32'(read_en), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_bus_out", 32'(bus_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready6", 32'(ready6), 32'd1);
`ifdef RXC_ERR_EN
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err6", 32'(err6), 32'd0);
`endif

        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i].src, tbl[i].dst, tbl[i].imm_sel, tbl[i].imm, tbl[i].re, tbl[i].we, tbl[i].bus);
            mdl[tbl[i].dst] = tbl[i].bus;
        end
`ifdef RXC_ERR_EN
        chk("err6_oob_sticky", 32'(err6), 32'd1);
        chk("err_clean", 32'(err), 32'd0);
`endif

        // back-to-back: valid held high, second request waits for req_ready
        overlap = 0;
        req_valid = 1'b1; req_imm_sel = 1'b1; req_imm = 16'h1111; req_src = 3'd0; req_dst = 3'd4;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("b2b_we1", 32'(write_en), 32'h10);
                chk("b2b_bus1", 32'(bus_out), 32'h1111);
                req_imm_sel = 1'b0; req_src = 3'd4; req_dst = 3'd6;
            end
            if (c == 2) chk("b2b_ready2", 32'(req_ready), 32'd0);
            if (c == 3) chk("b2b_ready3", 32'(req_ready), 32'd1);
            if (c == 4) begin
                chk("b2b_re4", 32'(read_en), 32'h10);
                req_valid = 1'b0;
            end
            if (c == 6) begin
                chk("b2b_we6", 32'(write_en), 32'h40);
                chk("b2b_bus6", 32'(bus_out), 32'h1111);
            end
            if (c == 7) chk("b2b_done7", 32'(done), 32'd1);
            if (read_en != 8'h0 && write_en != 8'h0) overlap++;
        end
        chk("b2b_overlap", 32'(overlap), 32'd0);
        mdl[4] = 16'h1111; mdl[6] = 16'h1111;
        chk("b2b_reg4", 32'(regs[4]), 32'h1111);
        chk("b2b_reg6", 32'(regs[6]), 32'h1111);

        // reset during READ: no write, controller idle next cycle
        req_valid = 1'b1; req_imm_sel = 1'b0; req_src = 3'd1; req_dst = 3'd6;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_read_en", 32'(read_en), 32'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_re", 32'(read_en), 32'd0);
        chk("mid_rst_we", 32'(write_en), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
`ifdef RXC_ERR_EN
        chk("mid_rst_err6", 32'(err6), 32'd0);
`endif
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_we", 32'(write_en), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
        end
        chk("post_rst_dst", 32'(regs[6]), 32'(mdl[6]));

        for (int k = 0; k < 20; k++) begin
            s  = 3'($urandom_range(0, 7));
            d  = 3'($urandom_range(0, 7));
            is = 1'($urandom_range(0, 1));
            im = 16'($urandom);
            ebus = is ? im : mdl[s];
            xfer(s, d, is, im, is ? 8'h00 : (8'd1 << s), 8'd1 << d, ebus);
            mdl[d] = ebus;
        end
        for (int i = 0; i < 8; i++) chk("final_reg", 32'(regs[i]), 32'(mdl[i]));

`ifdef RXC_ERR_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("cont_pre", 32'(err6), 32'd0);
        bus_in6 = 16'h0001;
        @(negedge clk);
        bus_in6 = 16'h0;
        chk("cont_set", 32'(err6), 32'd1);
        repeat (3) @(negedge clk);
        chk("cont_hold", 32'(err6), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("cont_clear", 32'(err6), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
